// File: rtl/ram_bank_arbiter.sv
// ram_bank_arbiter: shares one dual-port RAM bank between Control and a host channel.
// Control owns both ports. The host borrows whichever port Control leaves idle.
// A wait counter forces a single-cycle Control stall so the host is never starved.
// RAM read data arrives one cycle after the address is presented.
module ram_bank_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned HOST_MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    // Control datapath
    input  logic                  c_en_a,
    input  logic                  c_we_a,
    input  logic [ADDR_WIDTH-1:0] c_addr_a,
    input  logic                  c_en_b,
    input  logic                  c_we_b,
    input  logic [ADDR_WIDTH-1:0] c_addr_b,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_stall,
    output logic [DATA_WIDTH-1:0] c_rdata_a,
    output logic [DATA_WIDTH-1:0] c_rdata_b,
    // Host load/unload channel
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,
    // RAM side
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam int unsigned    CntW    = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxWait = CntW'(HOST_MAX_WAIT);

    logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                  rd_port_q, rd_port_d;    // 0: port A, 1: port B
    logic                  h_rvalid_q, h_rvalid_d;
    logic [DATA_WIDTH-1:0] h_rdata_q, h_rdata_d;

    logic                  hazard_a;
    logic                  hazard_b;
    logic                  forced;
    logic                  host_on_a;
    logic                  host_on_b;
    logic [DATA_WIDTH-1:0] rd_sel;

    // Arbitration: decide whether the host gets a port this cycle and which one.
    always_comb begin
        // A write on either side to a shared address would make ordering ambiguous.
        hazard_a  = c_en_a && (c_addr_a == h_addr) && (h_we || c_we_a);
        hazard_b  = c_en_b && (c_addr_b == h_addr) && (h_we || c_we_b);
        forced    = rstn && h_req && (wait_cnt_q == MaxWait);
        host_on_a = 1'b0;
        host_on_b = 1'b0;
        if (forced) begin
            // Control is suppressed entirely, so no hazard can exist.
            host_on_b = 1'b1;
        end else if (rstn && h_req && !hazard_a && !hazard_b) begin
            if (!c_en_b) begin
                host_on_b = 1'b1;
            end else if (!c_en_a) begin
                host_on_a = 1'b1;
            end
        end
        h_gnt   = host_on_a || host_on_b;
        c_stall = forced;
    end

    // RAM port steering: Control passes through unless the host owns the port.
    always_comb begin
        ram_we_a   = rstn && c_en_a && c_we_a && !forced;
        ram_addr_a = c_addr_a;
        ram_din_a  = c_wdata;
        ram_we_b   = rstn && c_en_b && c_we_b && !forced;
        ram_addr_b = c_addr_b;
        ram_din_b  = c_wdata;
        if (host_on_a) begin
            ram_we_a   = h_we;
            ram_addr_a = h_addr;
            ram_din_a  = h_wdata;
        end
        if (host_on_b) begin
            ram_we_b   = h_we;
            ram_addr_b = h_addr;
            ram_din_b  = h_wdata;
        end
    end

    assign c_rdata_a = ram_dout_a;
    assign c_rdata_b = ram_dout_b;

    // Starvation counter and read-return bookkeeping.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!h_req || h_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end

        rd_port_d = rd_port_q;
        if (h_gnt && !h_we) begin
            rd_port_d = host_on_b;
        end
        h_rvalid_d = h_gnt && !h_we;

        // Read data is live from the RAM in the valid cycle, then held.
        rd_sel    = rd_port_q ? ram_dout_b : ram_dout_a;
        h_rdata_d = h_rvalid_q ? rd_sel : h_rdata_q;
    end

    assign h_rvalid = h_rvalid_q;
    assign h_rdata  = h_rdata_d;

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q <= '0;
            rd_port_q  <= 1'b0;
            h_rvalid_q <= 1'b0;
            h_rdata_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_port_q  <= rd_port_d;
            h_rvalid_q <= h_rvalid_d;
            h_rdata_q  <= h_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed self-checking bench for ram_bank_arbiter with a behavioural dual-port RAM.
module tb_ram_bank_arbiter;

    logic        clk;
    logic        rstn;
    logic        c_en_a, c_we_a, c_en_b, c_we_b;
    logic [11:0] c_addr_a, c_addr_b;
    logic [63:0] c_wdata;
    logic        c_stall;
    logic [63:0] c_rdata_a, c_rdata_b;
    logic        h_req, h_we;
    logic [11:0] h_addr;
    logic [63:0] h_wdata;
    logic        h_gnt, h_rvalid;
    logic [63:0] h_rdata;
    logic        ram_we_a, ram_we_b;
    logic [11:0] ram_addr_a, ram_addr_b;
    logic [63:0] ram_din_a, ram_din_b;
    logic [63:0] ram_dout_a, ram_dout_b;

    logic        pre_en;
    logic [11:0] pre_addr;
    logic [63:0] pre_data;
    logic [63:0] mem [0:4095];

    int checks;
    int errors;

    ram_bank_arbiter #(
        .ADDR_WIDTH   (12),
        .DATA_WIDTH   (64),
        .HOST_MAX_WAIT(15)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .c_en_a    (c_en_a),
        .c_we_a    (c_we_a),
        .c_addr_a  (c_addr_a),
        .c_en_b    (c_en_b),
        .c_we_b    (c_we_b),
        .c_addr_b  (c_addr_b),
        .c_wdata   (c_wdata),
        .c_stall   (c_stall),
        .c_rdata_a (c_rdata_a),
        .c_rdata_b (c_rdata_b),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .ram_we_a  (ram_we_a),
        .ram_we_b  (ram_we_b),
        .ram_addr_a(ram_addr_a),
        .ram_addr_b(ram_addr_b),
        .ram_din_a (ram_din_a),
        .ram_din_b (ram_din_b),
        .ram_dout_a(ram_dout_a),
        .ram_dout_b(ram_dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read (old data on same-cycle write), bench preload port.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        ram_dout_a <= mem[ram_addr_a];
        ram_dout_b <= mem[ram_addr_b];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_en_a = 0; c_we_a = 0; c_addr_a = '0;
        c_en_b = 0; c_we_b = 0; c_addr_b = '0;
        c_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        pre_en = 1; pre_addr = a; pre_data = d;
        next_cycle();
        pre_en = 0;
    endtask

    task automatic test_reset();
        c_en_a = 1; c_we_a = 1; c_en_b = 1; c_we_b = 1;
        h_req = 1; h_addr = 12'h111;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", h_gnt); end
        checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", c_stall); end
        checks++; if ({ram_we_a, ram_we_b} !== 2'b00) begin errors++; $display("FAIL rst_we: got %b want 00", {ram_we_a, ram_we_b}); end
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", h_rvalid); end
        checks++; if (h_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", h_rdata); end
        checks++; if (dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL rst_waitcnt: got %0d want 0", dut.wait_cnt_q); end
        idle_inputs();
        next_cycle();
        rstn = 1;
        next_cycle();
    endtask

    task automatic test_host_idle_port_b();
        h_req = 1; h_we = 1; h_addr = 12'h123; h_wdata = 64'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1) begin errors++; $display("FAIL t1_wr_gnt: got %b want 1", h_gnt); end
        checks++; if (ram_we_b !== 1'b1 || ram_addr_b !== 12'h123 || ram_din_b !== 64'hDEAD_BEEF)
            begin errors++; $display("FAIL t1_wr_portb: got we=%b a=%h d=%h want 1 123 deadbeef", ram_we_b, ram_addr_b, ram_din_b); end
        checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL t1_wr_porta: got %b want 0", ram_we_a); end
        next_cycle();
        h_we = 0;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1 || ram_we_b !== 1'b0 || ram_addr_b !== 12'h123)
            begin errors++; $display("FAIL t1_rd_gnt: got gnt=%b we=%b a=%h want 1 0 123", h_gnt, ram_we_b, ram_addr_b); end
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL t1_wr_norvalid: got %b want 0", h_rvalid); end
        next_cycle();
        h_req = 0;
        @(negedge clk);
        checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL t1_rvalid: got %b want 1", h_rvalid); end
        checks++; if (h_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata: got %h want deadbeef", h_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL t1_rvalid_drop: got %b want 0", h_rvalid); end
        checks++; if (h_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata_hold: got %h want deadbeef", h_rdata); end
        next_cycle();
    endtask

    task automatic test_host_port_a();
        c_en_b = 1; c_we_b = 0; c_addr_b = 12'h300;
        h_req = 1; h_we = 0; h_addr = 12'h200;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1) begin errors++; $display("FAIL t2_gnt: got %b want 1", h_gnt); end
        checks++; if (ram_addr_a !== 12'h200 || ram_we_a !== 1'b0)
            begin errors++; $display("FAIL t2_porta: got a=%h we=%b want 200 0", ram_addr_a, ram_we_a); end
        checks++; if (ram_addr_b !== 12'h300) begin errors++; $display("FAIL t2_portb: got %h want 300", ram_addr_b); end
        next_cycle();
        h_req = 0;
        @(negedge clk);
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 64'h0123_4567_89AB_CDEF)
            begin errors++; $display("FAIL t2_rdata: got v=%b d=%h want 1 0123456789abcdef", h_rvalid, h_rdata); end
        checks++; if (c_rdata_b !== 64'hFEDC_BA98_7654_3210)
            begin errors++; $display("FAIL t2_crdata_b: got %h want fedcba9876543210", c_rdata_b); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starvation();
        c_en_a = 1; c_we_a = 1; c_addr_a = 12'h010;
        c_en_b = 1; c_we_b = 1; c_addr_b = 12'h011;
        c_wdata = 64'h5555;
        h_req = 1; h_we = 0; h_addr = 12'h050;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (h_gnt !== (i == 15)) begin errors++; $display("FAIL t3_gnt[%0d]: got %b want %b", i, h_gnt, i == 15); end
            checks++; if (c_stall !== (i == 15)) begin errors++; $display("FAIL t3_stall[%0d]: got %b want %b", i, c_stall, i == 15); end
            if (i == 15) begin
                checks++; if ({ram_we_a, ram_we_b} !== 2'b00 || ram_addr_b !== 12'h050)
                    begin errors++; $display("FAIL t3_stall_ports: got we=%b%b ab=%h want 00 050", ram_we_a, ram_we_b, ram_addr_b); end
            end else begin
                checks++; if ({ram_we_a, ram_we_b} !== 2'b11)
                    begin errors++; $display("FAIL t3_ctrl_we[%0d]: got %b want 11", i, {ram_we_a, ram_we_b}); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_hazard();
        c_en_a = 1; c_we_a = 1; c_addr_a = 12'h040; c_wdata = 64'hCAFE_F00D;
        h_req = 1; h_we = 0; h_addr = 12'h040;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (h_gnt !== 1'b0) begin errors++; $display("FAIL t4_hazard_gnt[%0d]: got %b want 0", i, h_gnt); end
            checks++; if (ram_we_a !== 1'b1 || ram_addr_a !== 12'h040 || ram_we_b !== 1'b0)
                begin errors++; $display("FAIL t4_hazard_ports[%0d]: got wa=%b aa=%h wb=%b want 1 040 0", i, ram_we_a, ram_addr_a, ram_we_b); end
            next_cycle();
        end
        c_addr_a = 12'h041; c_wdata = 64'h1111;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1 || ram_addr_b !== 12'h040 || ram_we_b !== 1'b0)
            begin errors++; $display("FAIL t4_moved_gnt: got g=%b ab=%h wb=%b want 1 040 0", h_gnt, ram_addr_b, ram_we_b); end
        next_cycle();
        h_req = 0; c_en_a = 0; c_we_a = 0;
        @(negedge clk);
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 64'hCAFE_F00D)
            begin errors++; $display("FAIL t4_rdata: got v=%b d=%h want 1 cafef00d", h_rvalid, h_rdata); end
        next_cycle();
        // Host write against a Control read of the same address is a hazard.
        c_en_a = 1; c_we_a = 0; c_addr_a = 12'h060;
        h_req = 1; h_we = 1; h_addr = 12'h060; h_wdata = 64'h77;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b0) begin errors++; $display("FAIL t4_wr_rd_hazard: got %b want 0", h_gnt); end
        next_cycle();
        c_addr_a = 12'h062;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1 || ram_we_b !== 1'b1 || ram_addr_b !== 12'h060 || ram_we_a !== 1'b0 || ram_addr_a !== 12'h062)
            begin errors++; $display("FAIL t4_both_proceed: got g=%b wb=%b ab=%h wa=%b aa=%h want 1 1 060 0 062",
                h_gnt, ram_we_b, ram_addr_b, ram_we_a, ram_addr_a); end
        next_cycle();
        h_we = 0; h_addr = 12'h062;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1) begin errors++; $display("FAIL t4_rd_rd_same: got %b want 1", h_gnt); end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        for (int i = 0; i < 10; i++) begin
            h_req = (i < 8); h_we = 0; h_addr = 12'h400 + 12'(i);
            @(negedge clk);
            checks++; if (h_gnt !== (i < 8)) begin errors++; $display("FAIL t5_gnt[%0d]: got %b want %b", i, h_gnt, i < 8); end
            checks++; if (h_rvalid !== (i >= 1 && i <= 8)) begin errors++; $display("FAIL t5_rvalid[%0d]: got %b want %b", i, h_rvalid, i >= 1 && i <= 8); end
            if (i >= 1 && i <= 8) begin
                exp = 64'hA5A5_0000_0000_0000 + 64'(i - 1) * 64'h111;
                checks++; if (h_rdata !== exp) begin errors++; $display("FAIL t5_rdata[%0d]: got %h want %h", i - 1, h_rdata, exp); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        h_req = 1; h_we = 0; h_addr = 12'h400;
        @(negedge clk);
        checks++; if (h_gnt !== 1'b1) begin errors++; $display("FAIL t6_gnt: got %b want 1", h_gnt); end
        rstn = 0;
        #1;
        checks++; if (h_gnt !== 1'b0) begin errors++; $display("FAIL t6_gnt_in_rst: got %b want 0", h_gnt); end
        next_cycle();
        h_req = 0;
        @(negedge clk);
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL t6_rvalid_in_rst: got %b want 0", h_rvalid); end
        rstn = 1;
        next_cycle();
        @(negedge clk);
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL t6_rvalid_after: got %b want 0", h_rvalid); end
        next_cycle();
        // Build up some wait count, then reset.
        c_en_a = 1; c_en_b = 1; c_addr_a = 12'h001; c_addr_b = 12'h002;
        h_req = 1; h_we = 0; h_addr = 12'h050;
        next_cycle(); next_cycle(); next_cycle();
        @(negedge clk);
        checks++; if (dut.wait_cnt_q !== 4'd3) begin errors++; $display("FAIL t6_waitcnt_pre: got %0d want 3", dut.wait_cnt_q); end
        rstn = 0;
        #1;
        checks++; if (dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL t6_waitcnt_rst: got %0d want 0", dut.wait_cnt_q); end
        idle_inputs();
        next_cycle();
        @(negedge clk);
        rstn = 1;
        next_cycle();
        @(negedge clk);
        checks++; if (dut.wait_cnt_q !== 4'd0) begin errors++; $display("FAIL t6_waitcnt_after: got %0d want 0", dut.wait_cnt_q); end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 0;
        pre_en = 0; pre_addr = '0; pre_data = '0;
        idle_inputs();
        #1;
        preload(12'h200, 64'h0123_4567_89AB_CDEF);
        preload(12'h300, 64'hFEDC_BA98_7654_3210);
        for (int i = 0; i < 8; i++) begin
            preload(12'h400 + 12'(i), 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h111);
        end
        test_reset();
        test_host_idle_port_b();
        test_host_port_a();
        test_starvation();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
